// File: rtl/data_memory_dumper_if.sv
// Memory read port plus byte-stream handshake between the dumper and its neighbours.
interface data_memory_dumper_if #(
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_DATA = 32
);
  logic               i_start;
  logic               o_mem_read_en;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] i_mem_read_data;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_done;

  // Dumper side
  modport master (
    input  i_start, i_mem_read_data, i_tx_ready,
    output o_mem_read_en, o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );

  // Memory / transmitter / controller side
  modport slave (
    output i_start, i_mem_read_data, i_tx_ready,
    input  o_mem_read_en, o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/data_memory_dumper.sv
// Streams the whole data memory out as bytes, MSB first, after a start pulse.
module data_memory_dumper #(
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned N_WORDS = 32
) (
  input  logic i_clock,
  input  logic i_reset,
  data_memory_dumper_if.master bus
);

  localparam int unsigned NB_IDX = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [NB_IDX-1:0]  word_idx;
  logic [1:0]         byte_cnt;
  logic [NB_DATA-1:0] shift;
  logic               read_en;
  logic               tx_valid;
  logic               busy;
  logic               done;

  // Address always follows word_idx; only the read strobe qualifies it
  assign bus.o_mem_addr    = NB_ADDR'({word_idx, 2'b00});
  assign bus.o_tx_data     = shift[NB_DATA-1 -: 8];
  assign bus.o_mem_read_en = read_en;
  assign bus.o_tx_valid    = tx_valid;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;

  // Sequencer: read word, capture it, shift out four bytes, repeat until the last word
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      word_idx <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      read_en  <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            word_idx <= '0;
            byte_cnt <= '0;
            read_en  <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          read_en <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          shift    <= bus.i_mem_read_data;
          byte_cnt <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (bus.i_tx_ready) begin
            shift    <= shift << 8;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              tx_valid <= 1'b0;
              if (word_idx == LAST_IDX) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                word_idx <= word_idx + NB_IDX'(1);
                read_en  <= 1'b1;
                state    <= READ;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          read_en  <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: 2-word instance for cycle-exact checks, 32-word instance for full dumps.
module tb_data_memory_dumper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_memory_dumper_if #(.NB_ADDR(32), .NB_DATA(32)) bus_a ();
  data_memory_dumper_if #(.NB_ADDR(32), .NB_DATA(32)) bus_b ();

  data_memory_dumper #(.NB_ADDR(32), .NB_DATA(32), .N_WORDS(2)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .bus(bus_a)
  );
  data_memory_dumper #(.NB_ADDR(32), .NB_DATA(32), .N_WORDS(32)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .bus(bus_b)
  );

  logic [31:0] mem_a [2];
  logic [31:0] mem_b [32];

  // Synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    if (bus_a.o_mem_read_en) bus_a.i_mem_read_data <= mem_a[bus_a.o_mem_addr[2]];
    if (bus_b.o_mem_read_en) bus_b.i_mem_read_data <= mem_b[bus_b.o_mem_addr[6:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle vector for the basic dump
  typedef struct {
    logic        ready;
    logic        re;
    logic [31:0] addr;
    logic        valid;
    logic [7:0]  data;
    logic        busy;
    logic        done;
  } vec_t;

  function automatic vec_t mk(input logic re, input logic [31:0] addr, input logic valid,
                              input logic [7:0] data, input logic busy, input logic done);
    vec_t v;
    v.ready = 1'b1; v.re = re; v.addr = addr; v.valid = valid;
    v.data = data; v.busy = busy; v.done = done;
    return v;
  endfunction

  // Results collected by the dump runners
  logic [7:0]  got_bytes[$];
  logic [31:0] got_addrs[$];
  int          n_done;
  int          done_cyc;

  task automatic start_a();
    bus_a.i_start = 1'b1;
    @(posedge clk); #1;
    bus_a.i_start = 1'b0;
  endtask

  task automatic start_b();
    bus_b.i_start = 1'b1;
    @(posedge clk); #1;
    bus_b.i_start = 1'b0;
  endtask

  // Run a dump on the 2-word instance; ready low in [stall_lo,stall_hi], extra start in restart_cyc
  task automatic run_a(input int stall_lo, input int stall_hi, input int restart_cyc);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       rdy;
    logic       finished;
    got_bytes.delete(); got_addrs.delete();
    n_done = 0; done_cyc = -1; prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
    start_a();
    for (int c = 1; c <= 60 && !finished; c++) begin
      rdy = !(c >= stall_lo && c <= stall_hi);
      bus_a.i_tx_ready = rdy;
      bus_a.i_start    = (c == restart_cyc);
      if (prev_stall) begin
        check("a_hold_valid", 64'(bus_a.o_tx_valid), 64'd1);
        check("a_hold_data", 64'(bus_a.o_tx_data), 64'(prev_data));
      end
      prev_stall = bus_a.o_tx_valid && !rdy;
      prev_data  = bus_a.o_tx_data;
      if (bus_a.o_mem_read_en) got_addrs.push_back(bus_a.o_mem_addr);
      if (bus_a.o_tx_valid && rdy) got_bytes.push_back(bus_a.o_tx_data);
      if (bus_a.o_done) begin n_done++; done_cyc = c; end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("a_busy_after_done", 64'(bus_a.o_busy), 64'd0);
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus_a.i_start = 1'b0;
    if (!finished) check("a_timeout", 64'd0, 64'd1);
  endtask

  // Run a full dump on the 32-word instance with random ready
  task automatic run_b();
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       rdy;
    logic       finished;
    got_bytes.delete(); got_addrs.delete();
    n_done = 0; done_cyc = -1; prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
    start_b();
    for (int c = 1; c <= 3000 && !finished; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      bus_b.i_tx_ready = rdy;
      if (prev_stall) begin
        check("b_hold_valid", 64'(bus_b.o_tx_valid), 64'd1);
        check("b_hold_data", 64'(bus_b.o_tx_data), 64'(prev_data));
      end
      prev_stall = bus_b.o_tx_valid && !rdy;
      prev_data  = bus_b.o_tx_data;
      if (bus_b.o_mem_read_en) got_addrs.push_back(bus_b.o_mem_addr);
      if (bus_b.o_tx_valid && rdy) got_bytes.push_back(bus_b.o_tx_data);
      if (bus_b.o_done) begin n_done++; done_cyc = c; end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("b_busy_after_done", 64'(bus_b.o_busy), 64'd0);
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("b_timeout", 64'd0, 64'd1);
  endtask

  // Reference: every word in address order, each split MSB first
  task automatic compare_dump(input string tag, input int nw, input logic [31:0] words[$]);
    check({tag, "_nreads"}, 64'(got_addrs.size()), 64'(nw));
    check({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(4 * nw));
    check({tag, "_ndone"}, 64'(n_done), 64'd1);
    for (int i = 0; i < nw && i < got_addrs.size(); i++)
      check({tag, "_addr"}, 64'(got_addrs[i]), 64'(4 * i));
    for (int k = 0; k < 4 * nw && k < got_bytes.size(); k++)
      check({tag, "_byte"}, 64'(got_bytes[k]), 64'((words[k / 4] >> (8 * (3 - (k % 4)))) & 32'hFF));
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_re"},    64'(bus_a.o_mem_read_en), 64'd0);
    check({tag, "_addr"},  64'(bus_a.o_mem_addr),    64'd0);
    check({tag, "_data"},  64'(bus_a.o_tx_data),     64'd0);
    check({tag, "_valid"}, 64'(bus_a.o_tx_valid),    64'd0);
    check({tag, "_busy"},  64'(bus_a.o_busy),        64'd0);
    check({tag, "_done"},  64'(bus_a.o_done),        64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[14];
    vec_t        v;
    logic [31:0] words_a[$];
    logic [31:0] words_b[$];

    bus_a.i_start = 1'b0; bus_a.i_tx_ready = 1'b0;
    bus_b.i_start = 1'b0; bus_b.i_tx_ready = 1'b0;
    mem_a[0] = 32'h11223344;
    mem_a[1] = 32'hAABBCCDD;
    words_a = '{32'h11223344, 32'hAABBCCDD};

    tbl[0]  = mk(1'b1, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 32'h0, 1'b1, 8'h11, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0, 1'b1, 8'h22, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 32'h0, 1'b1, 8'h33, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 32'h0, 1'b1, 8'h44, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 32'h4, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 32'h4, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 32'h4, 1'b1, 8'hAA, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 32'h4, 1'b1, 8'hBB, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 32'h4, 1'b1, 8'hCC, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 32'h4, 1'b1, 8'hDD, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 32'h4, 1'b0, 8'h00, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 32'h4, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    #2 rst = 1'b1;
    #1 check_a_zero("reset");
    check("reset_b_valid", 64'(bus_b.o_tx_valid), 64'd0);
    check("reset_b_busy",  64'(bus_b.o_busy),     64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic dump, cycle exact
    start_a();
    for (int c = 1; c <= 14; c++) begin
      v = tbl[c - 1];
      bus_a.i_tx_ready = v.ready;
      check($sformatf("basic_c%0d", c),
            64'({bus_a.o_mem_read_en, bus_a.o_mem_addr, bus_a.o_tx_valid,
                 (v.valid ? bus_a.o_tx_data : 8'h00), bus_a.o_busy, bus_a.o_done}),
            64'({v.re, v.addr, v.valid, v.data, v.busy, v.done}));
      @(posedge clk); #1;
    end

    // Backpressure on the first byte
    run_a(3, 5, -1);
    compare_dump("bp", 2, words_a);
    check("bp_done_cycle", 64'(done_cyc), 64'd16);

    // Start while busy is ignored
    run_a(-1, -1, 4);
    compare_dump("restart", 2, words_a);
    check("restart_done_cycle", 64'(done_cyc), 64'd13);

    // Reset in the middle of the first word
    start_a();
    bus_a.i_tx_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_valid_before", 64'(bus_a.o_tx_valid), 64'd1);
    rst = 1'b1;
    #1 check_a_zero("midreset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_a(-1, -1, -1);
    compare_dump("after_reset", 2, words_a);

    // Full depth, pattern contents then random contents
    for (int i = 0; i < 32; i++) mem_b[i] = 32'(i) * 32'h01010101;
    words_b.delete();
    for (int i = 0; i < 32; i++) words_b.push_back(mem_b[i]);
    run_b();
    compare_dump("full", 32, words_b);
    check("full_last_addr", 64'(got_addrs.size() > 0 ? got_addrs[got_addrs.size() - 1] : 32'hFFFF_FFFF), 64'h7C);

    for (int i = 0; i < 32; i++) mem_b[i] = $urandom;
    words_b.delete();
    for (int i = 0; i < 32; i++) words_b.push_back(mem_b[i]);
    run_b();
    compare_dump("rand", 32, words_b);

    // Idle quiet with ready toggling
    for (int c = 0; c < 50; c++) begin
      bus_a.i_tx_ready = c[0];
      bus_b.i_tx_ready = ~c[0];
      check("idle_a", 64'({bus_a.o_mem_read_en, bus_a.o_tx_valid, bus_a.o_busy, bus_a.o_done}), 64'd0);
      check("idle_b", 64'({bus_b.o_mem_read_en, bus_b.o_tx_valid, bus_b.o_busy, bus_b.o_done}), 64'd0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_dumper.md
# data_memory_dumper

Sequential reader that streams the whole data memory out as a byte stream for the debug path. On a start pulse it reads words in order, beginning at byte address 0, through the data memory's synchronous read port. It serialises each 32-bit word into 4 bytes, most-significant byte first, over a valid/ready byte interface toward the UART transmitter. It sits beside the MEM stage: the pipeline writes data memory, and this block reads it back once the program has halted.

## Interface
- NB_ADDR, 32, data memory byte-address width
- NB_DATA, 32, data memory word width; fixed at 32 (4 bytes per word)
- N_WORDS, 32, number of words dumped; ≥1, 4*N_WORDS ≤ 2^NB_ADDR
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- o_mem_read_en  out  1  data memory read strobe
- o_mem_addr  out  NB_ADDR  byte address = word_idx*4 (word_idx zero-extended, low 2 bits 0)
- i_mem_read_data  in  NB_DATA  read data; valid the cycle after o_mem_read_en
- o_tx_data  out  8  byte to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte when valid&ready at rising edge
- o_busy  out  1  high whenever state ≠ IDLE
- o_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- Registers: state, word_idx (clog2(N_WORDS) bits, min 1), byte_cnt (2 bits), shift (32 bits).
- IDLE: outputs inactive. When i_start=1, clear word_idx and byte_cnt, then go to READ.
- READ (1 cycle): o_mem_read_en=1 and o_mem_addr={word_idx,2'b00}. Then go to CAPTURE.
- CAPTURE (1 cycle): shift ← i_mem_read_data and byte_cnt ← 0. Then go to SEND.
- SEND: o_tx_valid=1 and o_tx_data=shift[31:24]. On valid&ready: shift ← shift<<8 and byte_cnt++.
  - Accepting byte 0, 1 or 2: stay in SEND.
  - Accepting byte 3 with word_idx = N_WORDS-1: go to DONE.
  - Accepting byte 3 otherwise: word_idx++, then go to READ.
- DONE (1 cycle): o_done=1. Then go to IDLE.
- o_mem_addr is driven from word_idx in every state. Only o_mem_read_en qualifies it.
- i_start outside IDLE is ignored. It is neither queued nor able to restart the dump.
- Exactly N_WORDS read strobes per dump, at addresses 0, 4, …, 4*(N_WORDS-1), in ascending order with no repeats.
- The block never writes memory.

## Timing
- Reset (asynchronous, immediate): state=IDLE, word_idx=0, byte_cnt=0, shift=0. All outputs 0: o_mem_read_en, o_mem_addr, o_tx_data, o_tx_valid, o_busy, o_done.
- Reset mid-dump: the transfer is abandoned and any presented byte is dropped. o_tx_valid falls asynchronously. The next start dumps again from address 0.
- Start latency: i_start sampled at edge k puts READ in cycle k+1, with o_busy=1 from cycle k+1.
- Memory read latency: 1 cycle, fixed. Data is captured at the end of CAPTURE.
- With i_tx_ready held high, each word takes 6 cycles (READ, CAPTURE, 4×SEND). A full dump is 6*N_WORDS cycles plus 1 DONE cycle.
- Handshake, while o_tx_valid=1 and i_tx_ready=0:
  - o_tx_data must hold stable.
  - o_tx_valid must stay high.
  - o_tx_valid never depends combinationally on i_tx_ready.
- i_tx_ready is a don't-care outside SEND.
- o_done is a single-cycle pulse. o_busy is still 1 in the DONE cycle and 0 the cycle after.
- Wrap: word_idx never exceeds N_WORDS-1. With N_WORDS=1 the block reads address 0 only.

## Test plan
- Basic dump: N_WORDS=2, mem[0]=0x11223344, mem[1]=0xAABBCCDD, i_tx_ready=1, start at edge 0. Required: read strobes in cycles 1 (addr 0x0) and 7 (addr 0x4); bytes 11,22,33,44,AA,BB,CC,DD in cycles 3–6 and 9–12; o_done in cycle 13; o_busy=0 in cycle 14.
- Backpressure: same memory contents, i_tx_ready=0 for cycles 3–5. Required: o_tx_data=0x11 and o_tx_valid=1 held in cycles 3–6; 0x11 accepted at edge 6; byte order unchanged; o_done 3 cycles later than in the basic dump.
- Start while busy: pulse i_start again in cycle 4. Required: no extra read strobe, exactly 8 bytes, one o_done pulse.
- Reset mid-dump: assert i_reset in cycle 5. Required: all outputs 0 immediately. A new start then produces a first read at addr 0x0 and a first byte of 0x11.
- Full depth: N_WORDS=32, mem[i]=i*0x01010101, random i_tx_ready. Required: 128 bytes in address order, 32 read strobes with the last at addr 0x7C, one o_done pulse.
- Idle quiet: no start for 50 cycles with i_tx_ready toggling. Required: o_mem_read_en, o_tx_valid, o_busy and o_done all stay 0.
